sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
- Shares the single-port SDRAM controller host interface between two requesters: port 0 (video line fetch, read-only) and port 1 (host/pixel writer, read or write).
- Sequences one 16-bit access at a time:
  - issues a one-cycle rd/wr enable;
  - confirms the controller accepted it via busy;
  - retries if a refresh swallowed the request;
  - returns data and an ack to the winning requester.
- Sits between the VGA/host logic and the SDRAM controller.

Parameters:
- ADDR_WIDTH, 20, host address width (bank+row+col), matches controller HADDR_WIDTH
- DATA_WIDTH, 16, data word width
- BUSY_TIMEOUT, 15, cycles to wait for ctl_busy after an enable pulse before retrying (must exceed the controller refresh sequence, ~12 cycles)
- STARVE_LIMIT, 8, consecutive port-0 grants while port 1 pends before port 1 is forced a grant

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req0  in  1  port 0 read request, held until ack0
- addr0  in  ADDR_WIDTH  port 0 address, stable while req0
- ack0  out  1  one-cycle completion pulse
- rdata0  out  DATA_WIDTH  read data, valid with ack0
- req1  in  1  port 1 request, held until ack1
- we1  in  1  port 1: 1=write, 0=read
- addr1  in  ADDR_WIDTH  port 1 address
- wdata1  in  DATA_WIDTH  port 1 write data
- ack1  out  1  one-cycle completion pulse
- rdata1  out  DATA_WIDTH  read data, valid with ack1 when we1=0
- ctl_rd_addr  out  ADDR_WIDTH  to controller rd_addr
- ctl_rd_enable  out  1  to controller rd_enable
- ctl_wr_addr  out  ADDR_WIDTH  to controller wr_addr
- ctl_wr_data  out  DATA_WIDTH  to controller wr_data
- ctl_wr_enable  out  1  to controller wr_enable
- ctl_rd_data  in  DATA_WIDTH  from controller rd_data
- ctl_rd_ready  in  1  from controller rd_ready
- ctl_busy  in  1  from controller busy

Behaviour:
- Reset:
  - state=IDLE
  - all ctl_* outputs 0
  - ack0/ack1 = 0; rdata0/rdata1 = 0
  - starve counter = 0; timeout counter = 0
  - reset mid-access abandons the access; no ack is generated.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DRAIN.
- IDLE:
  - entered only when ctl_busy=0.
  - Arbitration:
    - port 1 wins if req1 && (!req0 || starve_cnt==STARVE_LIMIT);
    - otherwise port 0 wins if req0;
    - otherwise stay in IDLE.
  - Latch the grant (gnt), we, addr and wdata into registers → ISSUE.
- Starve counter:
  - increments on each port-0 grant while req1=1 (saturates at STARVE_LIMIT);
  - clears on any port-1 grant or when req1=0.
- ISSUE (1 cycle):
  - Pulse exactly one enable: ctl_rd_enable, or ctl_wr_enable for a port-1 write.
  - ctl_rd_addr / ctl_wr_addr / ctl_wr_data are driven from the latched registers (held stable from ISSUE through WAIT_DONE).
  - Clear the timeout counter → WAIT_BUSY.
- WAIT_BUSY:
  - ctl_busy=1 → WAIT_DONE.
  - Otherwise the timeout counter increments; when it reaches BUSY_TIMEOUT → ISSUE (retry, same request; the controller was refreshing). Retries are unlimited.
- WAIT_DONE:
  - Read: on ctl_rd_ready=1, capture ctl_rd_data into rdata of the granted port and pulse its ack in the following cycle → DRAIN.
  - Write: on ctl_busy falling to 0, pulse ack → IDLE.
- DRAIN: wait for ctl_busy=0 → IDLE.
- Minimum gap between successive enable pulses is the controller access time plus 1 cycle.
- Enables are never asserted outside ISSUE; rd and wr enables are never asserted together.
- ack is asserted exactly once per request.
- A requester may deassert req only after its ack. If req drops early, the access still completes and the ack pulse is still emitted.
- Simultaneous req0 and req1 with starve_cnt < STARVE_LIMIT: port 0 wins.

Optional Feature:
- ARB_ROUND_ROBIN_EN
- Defined:
  - starve counter removed;
  - a last-grant bit selects the port other than the previous winner when both request;
  - a lone requester always wins.
- Undefined: fixed priority with STARVE_LIMIT as described above.

Test Plan:
- Port 0 read addr0=0x00123, controller model returns 0xBEEF → one enable pulse with ctl_rd_addr=0x00123; ack0 one cycle after ctl_rd_ready; rdata0=0xBEEF.
- Port 1 write addr1=0x0A5A5, wdata1=0x1234 → ctl_wr_enable pulse with matching addr/data; ack1 on the cycle after ctl_busy falls; rdata1 unchanged.
- Controller model ignores the first enable (busy low 12 cycles, simulating refresh) → retry pulse issued after BUSY_TIMEOUT=15 cycles; single ack0; exactly two enable pulses total.
- req0 held continuously and req1 asserted → port 1 is granted after exactly 8 port-0 grants. With ARB_ROUND_ROBIN_EN: grants alternate 0,1,0,1.
- rst asserted during WAIT_DONE of a read → next cycle all outputs 0, no ack; after release, a fresh req0 completes normally.
- Back-to-back req1 writes to 0x00000..0x00003 → four writes in order, four ack1 pulses, no enable issued while ctl_busy=1.

Source files
------------

// File: rtl/sdram_arbiter.sv
// Two-port arbiter in front of a single-port SDRAM controller host interface.
// Optional build macro ARB_ROUND_ROBIN_EN swaps starvation-limited fixed priority for round robin.
module sdram_arbiter #(
    parameter int ADDR_WIDTH   = 20,
    parameter int DATA_WIDTH   = 16,
    parameter int BUSY_TIMEOUT = 15,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    output logic                  ack0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [ADDR_WIDTH-1:0] ctl_rd_addr,
    output logic                  ctl_rd_enable,
    output logic [ADDR_WIDTH-1:0] ctl_wr_addr,
    output logic [DATA_WIDTH-1:0] ctl_wr_data,
    output logic                  ctl_wr_enable,
    input  logic [DATA_WIDTH-1:0] ctl_rd_data,
    input  logic                  ctl_rd_ready,
    input  logic                  ctl_busy
);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DRAIN} state_t;

    state_t                  state;
    state_t                  state_nx;
    logic                    gnt;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [TW-1:0]           tcnt;
    logic                    grant1;
    logic                    take;

    // A grant is taken only from IDLE and only once the controller is quiet.
    assign take = (state == IDLE) && !ctl_busy && (req0 || req1);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_gnt;

    assign grant1 = req1 && (!req0 || !last_gnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= 1'b1;
        end else if (take) begin
            last_gnt <= grant1;
        end
    end
`else
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_cnt;

    assign grant1 = req1 && (!req0 || starve_cnt == SW'(STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (rst || !req1) begin
            starve_cnt <= '0;
        end else if (take) begin
            if (grant1) begin
                starve_cnt <= '0;
            end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (take) state_nx = ISSUE;
            ISSUE:     state_nx = WAIT_BUSY;
            WAIT_BUSY: begin
                if (ctl_busy) begin
                    state_nx = WAIT_DONE;
                end else if (tcnt == TW'(BUSY_TIMEOUT - 1)) begin
                    state_nx = ISSUE;
                end
            end
            WAIT_DONE: begin
                if (!we_q && ctl_rd_ready) begin
                    state_nx = DRAIN;
                end else if (we_q && !ctl_busy) begin
                    state_nx = IDLE;
                end
            end
            DRAIN:     if (!ctl_busy) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            tcnt    <= '0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            state <= state_nx;
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        gnt     <= grant1;
                        we_q    <= grant1 && we1;
                        addr_q  <= grant1 ? addr1 : addr0;
                        wdata_q <= wdata1;
                    end
                end
                ISSUE:     tcnt <= '0;
                WAIT_BUSY: if (!ctl_busy) tcnt <= tcnt + 1'b1;
                WAIT_DONE: begin
                    // Read data is captured here; its ack follows one cycle later.
                    if (!we_q && ctl_rd_ready) begin
                        if (gnt) begin
                            rdata1 <= ctl_rd_data;
                            ack1   <= 1'b1;
                        end else begin
                            rdata0 <= ctl_rd_data;
                            ack0   <= 1'b1;
                        end
                    end else if (we_q && !ctl_busy) begin
                        ack1 <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ctl_rd_enable = (state == ISSUE) && !we_q;
    assign ctl_wr_enable = (state == ISSUE) && we_q;
    assign ctl_rd_addr   = addr_q;
    assign ctl_wr_addr   = addr_q;
    assign ctl_wr_data   = wdata_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter with a behavioural SDRAM controller model.
module tb_sdram_arbiter;
    localparam int AW = 20;
    localparam int DW = 16;
    localparam int BT = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0;
    logic [AW-1:0] addr0 = '0;
    logic          ack0;
    logic [DW-1:0] rdata0;
    logic          req1 = 1'b0;
    logic          we1 = 1'b0;
    logic [AW-1:0] addr1 = '0;
    logic [DW-1:0] wdata1 = '0;
    logic          ack1;
    logic [DW-1:0] rdata1;
    logic [AW-1:0] ctl_rd_addr;
    logic          ctl_rd_enable;
    logic [AW-1:0] ctl_wr_addr;
    logic [DW-1:0] ctl_wr_data;
    logic          ctl_wr_enable;
    logic [DW-1:0] ctl_rd_data = '0;
    logic          ctl_rd_ready = 1'b0;
    logic          ctl_busy = 1'b0;

    sdram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BUSY_TIMEOUT(BT), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .ctl_rd_addr(ctl_rd_addr), .ctl_rd_enable(ctl_rd_enable),
        .ctl_wr_addr(ctl_wr_addr), .ctl_wr_data(ctl_wr_data), .ctl_wr_enable(ctl_wr_enable),
        .ctl_rd_data(ctl_rd_data), .ctl_rd_ready(ctl_rd_ready), .ctl_busy(ctl_busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    logic [DW-1:0] exp0_q[$];
    logic [DW-1:0] exp1_q[$];
    logic          ord_q[$];
    logic [DW-1:0] mem [logic [AW-1:0]];
    logic [DW-1:0] rd1_last = '0;
    int            cyc = 0;
    int            n_en = 0;
    int            en_cyc[$];
    int            cnt = 0;
    logic          pend_rd = 1'b0;
    logic [DW-1:0] pend_data = '0;
    logic          drop_next = 1'b0;
    logic          prev_en = 1'b0;
    logic          busy_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Controller model and protocol monitor share one block so checks see pre-update model state.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            ctl_busy = 1'b0; ctl_rd_ready = 1'b0; cnt = 0; busy_prev = 1'b0; prev_en = 1'b0;
        end else begin
            if (ack0) begin
                if (ord_q.size() == 0 || exp0_q.size() == 0) check("ack0_unexpected", 1, 0);
                else begin
                    check("ack0_port", ord_q.pop_front(), 0);
                    check("rdata0", rdata0, exp0_q.pop_front());
                    check("ack0_after_ready", ctl_rd_ready, 1);
                end
            end
            if (ack1) begin
                if (ord_q.size() == 0 || exp1_q.size() == 0) check("ack1_unexpected", 1, 0);
                else begin
                    check("ack1_port", ord_q.pop_front(), 1);
                    check("rdata1", rdata1, exp1_q.pop_front());
                    if (we1) check("ack1_after_busy_fall", {busy_prev, ctl_busy}, 2'b10);
                    else check("ack1_after_ready", ctl_rd_ready, 1);
                end
            end
            if (ctl_rd_enable || ctl_wr_enable) begin
                n_en++;
                en_cyc.push_back(cyc);
                check("en_exclusive", ctl_rd_enable & ctl_wr_enable, 0);
                check("en_while_busy", ctl_busy, 0);
                check("en_single_cycle", prev_en, 0);
                if (ord_q.size() == 0) check("en_unexpected", 1, 0);
                else if (ord_q[0] == 1'b0) begin
                    check("p0_rd_en", ctl_rd_enable, 1);
                    check("p0_rd_addr", ctl_rd_addr, addr0);
                end else if (we1) begin
                    check("p1_wr_en", ctl_wr_enable, 1);
                    check("p1_wr_addr", ctl_wr_addr, addr1);
                    check("p1_wr_data", ctl_wr_data, wdata1);
                end else begin
                    check("p1_rd_en", ctl_rd_enable, 1);
                    check("p1_rd_addr", ctl_rd_addr, addr1);
                end
            end
            prev_en = ctl_rd_enable | ctl_wr_enable;
            busy_prev = ctl_busy;
            ctl_rd_ready = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 1 && pend_rd) begin
                    ctl_rd_ready = 1'b1;
                    ctl_rd_data = pend_data;
                end
                if (cnt == 0) ctl_busy = 1'b0;
            end else if (ctl_rd_enable || ctl_wr_enable) begin
                if (drop_next) drop_next = 1'b0;
                else begin
                    ctl_busy = 1'b1;
                    cnt = $urandom_range(3, 6);
                    pend_rd = ctl_rd_enable;
                    if (ctl_wr_enable) mem[ctl_wr_addr] = ctl_wr_data;
                    else pend_data = mem.exists(ctl_rd_addr) ? mem[ctl_rd_addr] : 16'hDEAD;
                end
            end
        end
    end

    task automatic wait_ack(input int port, input string tag);
        int i;
        for (i = 0; i < 400; i++) begin
            @(negedge clk);
            if (port == 0 ? ack0 : ack1) break;
        end
        if (i == 400) check(tag, 0, 1);
        #1;
    endtask

    task automatic read0(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic hold);
        mem[a] = d;
        addr0 = a;
        req0 = 1'b1;
        exp0_q.push_back(d);
        wait_ack(0, "ack0_timeout");
        if (!hold) req0 = 1'b0;
    endtask

    task automatic write1(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic hold);
        addr1 = a;
        wdata1 = d;
        we1 = 1'b1;
        req1 = 1'b1;
        exp1_q.push_back(rd1_last);
        wait_ack(1, "ack1_timeout");
        if (!hold) req1 = 1'b0;
    endtask

    task automatic read1(input logic [AW-1:0] a, input logic [DW-1:0] d);
        addr1 = a;
        we1 = 1'b0;
        req1 = 1'b1;
        exp1_q.push_back(d);
        rd1_last = d;
        wait_ack(1, "ack1_timeout");
        req1 = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we1 = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        rd1_last = '0;
        ord_q.delete(); exp0_q.delete(); exp1_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ack0"}, ack0, 0);
        check({tag, "_ack1"}, ack1, 0);
        check({tag, "_rdata0"}, rdata0, 0);
        check({tag, "_rdata1"}, rdata1, 0);
        check({tag, "_rd_en"}, ctl_rd_enable, 0);
        check({tag, "_wr_en"}, ctl_wr_enable, 0);
        check({tag, "_rd_addr"}, ctl_rd_addr, 0);
        check({tag, "_wr_addr"}, ctl_wr_addr, 0);
        check({tag, "_wr_data"}, ctl_wr_data, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int gap;
        int i;
        logic [AW-1:0] a;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        do_reset();

        // Single port-0 read
        base = n_en;
        ord_q.push_back(1'b0);
        read0(20'h00123, 16'hBEEF, 1'b0);
        check("p0_read_en_count", n_en - base, 1);

        // Port-1 write then read back
        ord_q.push_back(1'b1);
        write1(20'h0A5A5, 16'h1234, 1'b0);
        a = 20'h0A5A5;
        check("p1_write_mem", mem[a], 16'h1234);
        ord_q.push_back(1'b1);
        read1(20'h0A5A5, 16'h1234);

        // First enable swallowed by a refresh
        repeat (3) @(negedge clk);
        #1;
        drop_next = 1'b1;
        en_cyc.delete();
        base = n_en;
        ord_q.push_back(1'b0);
        read0(20'h00777, 16'h5A5A, 1'b0);
        check("retry_en_count", n_en - base, 2);
        gap = (en_cyc.size() >= 2) ? en_cyc[1] - en_cyc[0] : 0;
        check("retry_gap_in_range", (gap >= BT && gap <= BT + 2), 1);

        // Reset while a read waits for data
        repeat (3) @(negedge clk);
        #1;
        mem[20'h00321] = 16'h7777;
        addr0 = 20'h00321;
        req0 = 1'b1;
        ord_q.push_back(1'b0);
        for (i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (ctl_busy) break;
        end
        if (i == 50) check("rst_test_busy_timeout", 0, 1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        req0 = 1'b0;
        @(negedge clk);
        #1;
        check_idle_outputs("midreset");
        do_reset();
        repeat (10) @(negedge clk);
        #1;
        ord_q.push_back(1'b0);
        read0(20'h00321, 16'h7777, 1'b0);

        // Back-to-back port-1 writes
        for (int k = 0; k < 4; k++) ord_q.push_back(1'b1);
        for (int k = 0; k < 4; k++) write1(AW'(k), 16'hC000 + 16'(k), k < 3);
        for (int k = 0; k < 4; k++) begin
            a = AW'(k);
            check("b2b_mem", mem.exists(a) ? mem[a] : 16'hXXXX, 16'hC000 + 16'(k));
        end

        // Contention: port 0 streaming, port 1 pending
        do_reset();
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 0; k < 5; k++) begin ord_q.push_back(1'b0); ord_q.push_back(1'b1); end
        for (int k = 0; k < 5; k++) ord_q.push_back(1'b0);
`else
        for (int k = 0; k < 8; k++) ord_q.push_back(1'b0);
        ord_q.push_back(1'b1);
        ord_q.push_back(1'b0);
        ord_q.push_back(1'b0);
        for (int k = 0; k < 4; k++) ord_q.push_back(1'b1);
`endif
        fork
            for (int k = 0; k < 10; k++) read0(20'h40000 + AW'(k), 16'h4000 + 16'(k), k < 9);
            for (int k = 0; k < 5; k++) write1(20'h80000 + AW'(k), 16'h8000 + 16'(k), k < 4);
        join

        repeat (5) @(negedge clk);
        check("ord_q_drained", ord_q.size(), 0);
        check("exp0_q_drained", exp0_q.size(), 0);
        check("exp1_q_drained", exp1_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
